// File: rtl/jk_bank_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_ctrl_if
// Description : Command and status bundle for jk_bank_ctrl.
//               master : drives cmd_valid/cmd_op/cmd_mask/cmd_count and
//                        observes cmd_ready, j_out, k_out, q, busy, done, err.
//               slave  : the controller side of the same signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface jk_bank_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output cmd_valid, cmd_op, cmd_mask, cmd_count,
    input  cmd_ready, j_out, k_out, q, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mask, cmd_count,
    output cmd_ready, j_out, k_out, q, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/jk_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_ctrl
// Description : Command-driven sequencer over a bank of WIDTH JK flip-flops.
//               Accepts one command per valid/ready handshake and drives the
//               per-bit J/K vectors for SET, CLR, TGL, COUNT and SHIFT.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               bus  - jk_bank_ctrl_if.slave (command in, J/K/q/status out)
// Revision    : 1.0 - initial release
// ============================================================================
module jk_bank_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  jk_bank_ctrl_if.slave     bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_SET   = 3'd1;
  localparam logic [2:0] OP_CLR   = 3'd2;
  localparam logic [2:0] OP_TGL   = 3'd3;
  localparam logic [2:0] OP_COUNT = 3'd4;
  localparam logic [2:0] OP_SHIFT = 3'd5;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_mask;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [WIDTH-1:0] r_q;

  logic             w_accept;
  logic             w_multi_in;
  logic             w_reserved_in;
  logic             w_skip_exec;
  logic             w_multi_op;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_shift_in;

  assign w_accept      = bus.cmd_valid && (r_state == S_IDLE);
  assign w_multi_in    = (bus.cmd_op == OP_COUNT) || (bus.cmd_op == OP_SHIFT);
  assign w_reserved_in = (bus.cmd_op > OP_SHIFT);
  // Commands with nothing to execute bypass EXEC entirely.
  assign w_skip_exec   = (bus.cmd_op == OP_NOP) || w_reserved_in ||
                         (w_multi_in && (bus.cmd_count == '0));
  assign w_multi_op    = (r_op == OP_COUNT) || (r_op == OP_SHIFT);

  // Ripple carry for the up-counter: bit i toggles when all lower bits are 1.
  assign w_carry[0] = 1'b1;
  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_carry
    assign w_carry[gi] = w_carry[gi-1] & r_q[gi-1];
  end

  // Left shift with mask[0] as serial input; MSB falls off.
  assign w_shift_in = {r_q[WIDTH-2:0], r_mask[0]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_skip_exec ? S_DONE : S_EXEC;
      S_EXEC: begin
        // r_cnt holds steps remaining including the current one.
        if (!w_multi_op || (r_cnt == CNT_W'(1))) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs and J/K drive
  always_comb begin
    bus.cmd_ready = (r_state == S_IDLE);
    bus.busy      = (r_state == S_EXEC);
    bus.done      = (r_state == S_DONE);
    w_j = '0;
    w_k = '0;
    if (r_state == S_EXEC) begin
      case (r_op)
        OP_SET:   w_j = r_mask;
        OP_CLR:   w_k = r_mask;
        OP_TGL:   begin w_j = r_mask;     w_k = r_mask;      end
        OP_COUNT: begin w_j = w_carry;    w_k = w_carry;     end
        OP_SHIFT: begin w_j = w_shift_in; w_k = ~w_shift_in; end
        default:  begin w_j = '0;         w_k = '0;          end
      endcase
    end
  end

  assign bus.j_out = w_j;
  assign bus.k_out = w_k;
  assign bus.q     = r_q;
  assign bus.err   = r_err;

  // Command latch, step counter and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= OP_NOP;
      r_mask <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_op   <= bus.cmd_op;
      r_mask <= bus.cmd_mask;
      r_cnt  <= bus.cmd_count;
      r_err  <= w_reserved_in;
    end else if ((r_state == S_EXEC) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // JK bank: q+ = J&~q | ~K&q per bit (00 hold, 01 clear, 10 set, 11 toggle)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= '0;
    else     r_q <= (w_j & ~r_q) | (~w_k & r_q);
  end

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_bank_ctrl
// Description : Self-checking bench for jk_bank_ctrl. A stimulus table feeds
//               commands; expected results are queued per command and
//               compared when done pulses. Every EXEC cycle J/K and q are
//               checked against an independent JK model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_bank_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jk_bank_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  jk_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] mask;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] exp_q;
    logic             exp_err;
    int               exp_busy;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             err;
    int               busy;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  logic [2:0]       cur_op;
  logic [WIDTH-1:0] cur_mask;
  logic [WIDTH-1:0] model_q;
  int busy_cnt;
  int rdy_lo_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Independent expected J/K for the current command and q.
  function automatic void exp_jk(input logic [2:0] op, input logic [WIDTH-1:0] m,
                                 input logic [WIDTH-1:0] qv,
                                 output logic [WIDTH-1:0] j, output logic [WIDTH-1:0] k);
    logic c;
    j = '0; k = '0;
    case (op)
      3'd1: j = m;
      3'd2: k = m;
      3'd3: begin j = m; k = m; end
      3'd4: begin
        c = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin j[i] = c; k[i] = c; c = c & qv[i]; end
      end
      3'd5: begin
        j[0] = m[0]; k[0] = ~m[0];
        for (int i = 1; i < WIDTH; i++) begin j[i] = qv[i-1]; k[i] = ~qv[i-1]; end
      end
      default: ;
    endcase
  endfunction

  // Monitor: samples on the falling edge.
  always @(negedge clk) begin
    logic [WIDTH-1:0] ej, ek;
    exp_t e;
    if (rst) begin
      busy_cnt   = 0;
      rdy_lo_cnt = 0;
      model_q    = '0;
    end else begin
      if (!bus.cmd_ready) rdy_lo_cnt++;
      if (bus.cmd_ready) begin
        chk("idle_j", 32'(bus.j_out), 32'(0));
        chk("idle_k", 32'(bus.k_out), 32'(0));
      end
      if (bus.busy) begin
        busy_cnt++;
        exp_jk(cur_op, cur_mask, model_q, ej, ek);
        chk("exec_q", 32'(bus.q), 32'(model_q));
        chk("exec_j", 32'(bus.j_out), 32'(ej));
        chk("exec_k", 32'(bus.k_out), 32'(ek));
        model_q = (ej & ~model_q) | (~ek & model_q);
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("done_q", 32'(bus.q), 32'(e.q));
          chk("done_err", 32'(bus.err), 32'(e.err));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.busy));
          chk("ready_low_cycles", 32'(rdy_lo_cnt), 32'(e.busy + 1));
        end
        busy_cnt   = 0;
        rdy_lo_cnt = 0;
      end
    end
  end

  // Waits for IDLE, presents the command, returns #1 after the acceptance edge.
  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] m,
                      input logic [CNT_W-1:0] cnt, input logic [WIDTH-1:0] eq,
                      input logic ee, input int eb);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!bus.cmd_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("ready_timeout", 32'(0), 32'(1));
    bus.cmd_op    = op;
    bus.cmd_mask  = m;
    bus.cmd_count = cnt;
    bus.cmd_valid = 1'b1;
    cur_op   = op;
    cur_mask = m;
    e.q = eq; e.err = ee; e.busy = eb;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom_range(0, 7));
    bus.cmd_mask  = WIDTH'($urandom);
  endtask

  vec_t vt[16];

  initial begin
    int t;
    vt[0]  = '{3'd1, 4'b1010, 8'd0,  4'b1010, 1'b0, 1};
    vt[1]  = '{3'd3, 4'b1111, 8'd0,  4'b0101, 1'b0, 1};
    vt[2]  = '{3'd2, 4'b0100, 8'd0,  4'b0001, 1'b0, 1};
    vt[3]  = '{3'd2, 4'b1111, 8'd0,  4'b0000, 1'b0, 1};
    vt[4]  = '{3'd4, 4'b0000, 8'd20, 4'b0100, 1'b0, 20};
    vt[5]  = '{3'd2, 4'b1111, 8'd0,  4'b0000, 1'b0, 1};
    vt[6]  = '{3'd1, 4'b0001, 8'd0,  4'b0001, 1'b0, 1};
    vt[7]  = '{3'd5, 4'b0001, 8'd3,  4'b1111, 1'b0, 3};
    vt[8]  = '{3'd5, 4'b1110, 8'd1,  4'b1110, 1'b0, 1};
    vt[9]  = '{3'd4, 4'b0000, 8'd0,  4'b1110, 1'b0, 0};
    vt[10] = '{3'd6, 4'b1111, 8'd5,  4'b1110, 1'b1, 0};
    vt[11] = '{3'd1, 4'b0001, 8'd0,  4'b1111, 1'b0, 1};
    vt[12] = '{3'd0, 4'b1111, 8'd9,  4'b1111, 1'b0, 0};
    vt[13] = '{3'd7, 4'b0000, 8'd0,  4'b1111, 1'b1, 0};
    vt[14] = '{3'd3, 4'b0011, 8'd0,  4'b1100, 1'b0, 1};
    vt[15] = '{3'd5, 4'b0000, 8'd2,  4'b0000, 1'b0, 2};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_mask  = '0;
    bus.cmd_count = '0;
    cur_op = '0; cur_mask = '0;

    // Reset state
    #1;
    chk("rst_q", 32'(bus.q), 32'(0));
    chk("rst_ready", 32'(bus.cmd_ready), 32'(1));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_err", 32'(bus.err), 32'(0));
    chk("rst_jk", 32'({bus.j_out, bus.k_out}), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) send(vt[i].op, vt[i].mask, vt[i].count, vt[i].exp_q, vt[i].exp_err, vt[i].exp_busy);

    // Wrap: 1100 + COUNT 6 -> 0010 (via 1111 -> 0000)
    send(3'd1, 4'b1100, 8'd0, 4'b1100, 1'b0, 1);
    send(3'd4, 4'b0000, 8'd6, 4'b0010, 1'b0, 6);

    // Async reset 5 cycles into a long COUNT: immediate clear, no done.
    send(3'd4, 4'b0000, 8'd20, 4'b0000, 1'b0, 20);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_q", 32'(bus.q), 32'(0));
    chk("abort_ready", 32'(bus.cmd_ready), 32'(1));
    chk("abort_busy", 32'(bus.busy), 32'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send(3'd1, 4'b0101, 8'd0, 4'b0101, 1'b0, 1);

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(negedge clk); t++; end
    chk("drain_queue", 32'(exp_q.size()), 32'(0));
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
